// File: rtl/cms_pix28_cmd_issuer.sv
// Host-side command issuer for the CMS pix28 firmware: formats one command word per
// request, hands it over valid/ready, polls the firmware status word and answers once.
`timescale 1ns/1ps
module cms_pix28_cmd_issuer #(
  parameter int FW_IP          = 1,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter bit AUTO_CLEAR     = 1'b1
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_device_id,
  input  logic [3:0]  req_op_code,
  input  logic [23:0] req_body,
  input  logic        req_wait_test,
  output logic [31:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] fw_status,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid && ready are both
  // high; valid never drops and the payload never changes while waiting for ready.

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_ACK    = 3'd2,
    S_WAIT_TEST   = 3'd3,
    S_CLEAR_ISSUE = 3'd4,
    S_RESP        = 3'd5
  } state_t;

  localparam logic [3:0]  OP_NOOP      = 4'h0;
  localparam logic [3:0]  OP_CLEAR     = 4'hE;
  localparam logic [3:0]  OP_W_EXECUTE = 4'hF;
  localparam logic [1:0]  RSP_OK       = 2'd0;
  localparam logic [1:0]  RSP_ERR_CFG  = 2'd1;
  localparam logic [1:0]  RSP_TIMEOUT  = 2'd2;
  localparam logic [1:0]  RSP_BAD_ARG  = 2'd3;
  localparam logic [23:0] TMO_LAST     = 24'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cmd_word;
  logic [3:0]  r_op;
  logic        r_wait_test;
  logic [3:0]  r_test_num;
  logic [1:0]  r_rsp_code;
  logic [23:0] r_timer;

  logic [3:0]  w_req_test;
  logic        w_onehot;
  logic        w_bad_arg;
  logic        w_has_ack;
  logic [3:0]  w_ack_idx;
  logic        w_ack_hit;
  logic        w_test_hit;
  logic        w_tmo;
  logic        w_accept;
  logic        w_enter_clear;
  logic        w_code_en;
  logic [1:0]  w_code;
  logic        w_timer_clr;

  assign w_req_test = (FW_IP == 1) ? req_body[17:14] : req_body[15:12];
  assign w_onehot   = (w_req_test != 4'd0) && ((w_req_test & (w_req_test - 4'd1)) == 4'd0);
  assign w_bad_arg  = (req_op_code == OP_W_EXECUTE) && req_wait_test && !w_onehot;

  // Op codes 1..13 acknowledge on status bit op-1; execute uses bit 13.
  always_comb begin
    w_has_ack = 1'b1;
    w_ack_idx = 4'd0;
    case (r_op)
      OP_NOOP, OP_CLEAR: w_has_ack = 1'b0;
      OP_W_EXECUTE:      w_ack_idx = 4'd13;
      default:           w_ack_idx = r_op - 4'd1;
    endcase
  end

  assign w_ack_hit  = fw_status[w_ack_idx];
  // Test number is one-hot, so its bit i lines up with done bit 14+i.
  assign w_test_hit = |(r_test_num & fw_status[17:14]);
  assign w_tmo      = (r_timer == TMO_LAST);

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_enter_clear = 1'b0;
    w_code_en     = 1'b0;
    w_code        = RSP_OK;
    w_timer_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_bad_arg) begin
            w_next    = S_RESP;
            w_code_en = 1'b1;
            w_code    = RSP_BAD_ARG;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          if (!w_has_ack) begin
            w_next    = S_RESP;
            w_code_en = 1'b1;
            w_code    = RSP_OK;
          end else begin
            w_next      = S_WAIT_ACK;
            w_timer_clr = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        if (w_ack_hit) begin
          if ((r_op == OP_W_EXECUTE) && r_wait_test) begin
            w_next      = S_WAIT_TEST;
            w_timer_clr = 1'b1;
          end else begin
            w_next        = S_CLEAR_ISSUE;
            w_enter_clear = 1'b1;
            w_code_en     = 1'b1;
            w_code        = RSP_OK;
          end
        end else if (w_tmo) begin
          w_next        = S_CLEAR_ISSUE;
          w_enter_clear = 1'b1;
          w_code_en     = 1'b1;
          w_code        = RSP_TIMEOUT;
        end
      end
      S_WAIT_TEST: begin
        if (fw_status[31] || w_test_hit || w_tmo) begin
          w_next        = S_CLEAR_ISSUE;
          w_enter_clear = 1'b1;
          w_code_en     = 1'b1;
          if (fw_status[31])   w_code = RSP_ERR_CFG;
          else if (w_test_hit) w_code = RSP_OK;
          else                 w_code = RSP_TIMEOUT;
        end
      end
      S_CLEAR_ISSUE: begin
        if (!AUTO_CLEAR || cmd_ready) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      r_cmd_word  <= 32'd0;
      r_op        <= 4'd0;
      r_wait_test <= 1'b0;
      r_test_num  <= 4'd0;
      r_rsp_code  <= 2'd0;
      r_timer     <= 24'd0;
    end else begin
      if (w_accept) begin
        r_cmd_word  <= {req_device_id, req_op_code, req_body};
        r_op        <= req_op_code;
        r_wait_test <= req_wait_test;
        r_test_num  <= w_req_test;
      end else if (w_enter_clear && AUTO_CLEAR) begin
        r_cmd_word <= {r_cmd_word[31:28], OP_CLEAR, 24'h0};
      end
      if (w_code_en) r_rsp_code <= w_code;
      if (w_timer_clr)
        r_timer <= 24'd0;
      else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_TEST))
        r_timer <= r_timer + 24'd1;
    end
  end

  assign cmd_word  = r_cmd_word;
  assign cmd_valid = (r_state == S_ISSUE) || (AUTO_CLEAR && (r_state == S_CLEAR_ISSUE));
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_code  = r_rsp_code;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cms_pix28_cmd_issuer.sv
// Bench for cms_pix28_cmd_issuer: table of requests with scripted firmware status,
// plus hand sequences for latency, timeout length, pre-set status and abort by reset.
`timescale 1ns/1ps
module tb_cms_pix28_cmd_issuer;

  localparam int         TMO          = 16;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_TEST = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_device_id = 4'd0;
  logic [3:0]  req_op_code = 4'd0;
  logic [23:0] req_body = 24'd0;
  logic        req_wait_test = 1'b0;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] fw_status = 32'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic        busy;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  cms_pix28_cmd_issuer #(.FW_IP(2), .TIMEOUT_CYCLES(TMO), .AUTO_CLEAR(1'b1)) u_dut (
    .fw_axi_clk(clk), .fw_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_device_id(req_device_id), .req_op_code(req_op_code),
    .req_body(req_body), .req_wait_test(req_wait_test),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fw_status(fw_status),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  op;
    logic [23:0] body;
    logic        wt;
    int          ack_dly;   // cycles after handshake before ack bit; -1 never
    int          test_dly;  // cycles after ack before test-done bit; -1 never
    logic        err;       // raise bit 31 together with the test-done bit
    logic [1:0]  code;      // expected response code
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cmd_hs_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_rsp_q[$];
  vec_t        vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event expected one", name);
  endtask

  function automatic int ack_bit(input logic [3:0] op);
    case (op)
      4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'h4: return 3;
      4'h5: return 4;   4'h6: return 5;   4'h7: return 6;   4'h8: return 7;
      4'h9: return 8;   4'hA: return 9;   4'hB: return 10;  4'hC: return 11;
      4'hD: return 12;  4'hF: return 13;
      default: return -1;
    endcase
  endfunction

  function automatic int test_bit(input logic [3:0] t);
    case (t)
      4'd1: return 14;  4'd2: return 15;  4'd4: return 16;  4'd8: return 17;
      default: return 31;
    endcase
  endfunction

  function automatic bit is_bad(input vec_t v);
    logic [3:0] t;
    t = v.body[15:12];
    return (v.op == 4'hF) && v.wt && !(t == 4'd1 || t == 4'd2 || t == 4'd4 || t == 4'd8);
  endfunction

  function automatic void push_exp(input vec_t v);
    if (!is_bad(v)) begin
      exp_q.push_back({v.id, v.op, v.body});
      if (v.op != 4'h0 && v.op != 4'hE) exp_q.push_back({v.id, 4'hE, 24'h0});
    end
    exp_rsp_q.push_back(v.code);
  endfunction

  // Scoreboard: every word transfer and every response pops the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL cmd_unexpected: got 0x%0h expected no transfer", cmd_word);
        end else check("cmd_word", cmd_word, exp_q.pop_front());
        cmd_hs_cnt++;
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rsp_unexpected: got code %0d expected no response", rsp_code);
        end else check("rsp_code", 32'(rsp_code), 32'(exp_rsp_q.pop_front()));
        rsp_cnt++;
      end
    end
  end

  task automatic send_req(input logic [3:0] id, input logic [3:0] op,
                          input logic [23:0] body, input logic wt);
    @(posedge clk); #1;
    check("req_ready_before_req", 32'(req_ready), 32'd1);
    req_device_id = id; req_op_code = op; req_body = body; req_wait_test = wt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    while (cmd_hs_cnt < target && n < 60) begin @(posedge clk); n++; end
    if (cmd_hs_cnt < target) note_fail(name);
  endtask

  task automatic wait_rsp(input int target, input string name);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 100) begin @(posedge clk); n++; end
    if (rsp_cnt < target) note_fail(name);
  endtask

  task automatic run_vec(input vec_t v);
    int rs;
    int hs;
    rs = rsp_cnt;
    hs = cmd_hs_cnt;
    push_exp(v);
    send_req(v.id, v.op, v.body, v.wt);
    if (!is_bad(v)) begin
      wait_hs(hs + 1, "cmd_handshake");
      if (v.ack_dly >= 0 && ack_bit(v.op) >= 0) begin
        repeat (v.ack_dly) @(posedge clk);
        #1 fw_status[ack_bit(v.op)] = 1'b1;
        if (v.test_dly >= 0) begin
          repeat (v.test_dly) @(posedge clk);
          check("no_rsp_before_test_done", 32'(rsp_cnt), 32'(rs));
          #1 fw_status[test_bit(v.body[15:12])] = 1'b1;
          if (v.err) fw_status[31] = 1'b1;
        end
      end
    end
    wait_rsp(rs + 1, "rsp_wait");
    #1 fw_status = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    int   n2;
    int   rs;
    bit   got;

    vecs[0]  = '{4'h1, 4'h2, 24'h001234, 1'b0, 5,  -1, 1'b0, 2'd0};
    vecs[1]  = '{4'h3, 4'hF, 24'h004000, 1'b1, 3,  4,  1'b0, 2'd0};
    vecs[2]  = '{4'h3, 4'hF, 24'h004000, 1'b1, 3,  4,  1'b1, 2'd1};
    vecs[3]  = '{4'h5, 4'hF, 24'h003000, 1'b1, -1, -1, 1'b0, 2'd3};
    vecs[4]  = '{4'h6, 4'hF, 24'h000000, 1'b1, -1, -1, 1'b0, 2'd3};
    vecs[5]  = '{4'h7, 4'hF, 24'h003000, 1'b0, 2,  -1, 1'b0, 2'd0};
    vecs[6]  = '{4'h2, 4'hF, 24'h001000, 1'b1, 1,  -1, 1'b0, 2'd2};
    vecs[7]  = '{4'hA, 4'h9, 24'hABCDEF, 1'b0, 0,  -1, 1'b0, 2'd0};
    vecs[8]  = '{4'hF, 4'hD, 24'h123456, 1'b0, 7,  -1, 1'b0, 2'd0};
    vecs[9]  = '{4'h4, 4'hE, 24'h000000, 1'b0, -1, -1, 1'b0, 2'd0};
    vecs[10] = '{4'h9, 4'h0, 24'h00BEEF, 1'b0, -1, -1, 1'b0, 2'd0};
    vecs[11] = '{4'h8, 4'h1, 24'h000001, 1'b0, 15, -1, 1'b0, 2'd0};
    vecs[12] = '{4'h8, 4'h1, 24'h000002, 1'b0, 16, -1, 1'b0, 2'd2};
    vecs[13] = '{4'hB, 4'hF, 24'h008000, 1'b1, 0,  16, 1'b0, 2'd0};
    vecs[14] = '{4'hC, 4'hF, 24'h020000, 1'b1, -1, -1, 1'b0, 2'd3};

    // Reset state.
    @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_word", cmd_word, 32'd0);
    check("rst_rsp_code", 32'(rsp_code), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // NOOP latency: accept cycle, ISSUE, RESP.
    v = '{4'h6, 4'h0, 24'h000011, 1'b0, -1, -1, 1'b0, 2'd0};
    push_exp(v);
    send_req(v.id, v.op, v.body, v.wt);
    n = 0; got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; n = i; end
    end
    check("noop_accept_to_rsp_cycles", 32'(n + 1), 32'd3);

    // Timeout length in WAIT_ACK.
    v = '{4'h2, 4'h8, 24'h55AA00, 1'b0, -1, -1, 1'b0, 2'd2};
    rs = rsp_cnt;
    push_exp(v);
    send_req(v.id, v.op, v.body, v.wt);
    n = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (dbg_state == ST_WAIT_ACK) n++;
      if (dbg_state == ST_RESP) got = 1'b1;
    end
    check("wait_ack_timeout_cycles", 32'(n), 32'(TMO));
    wait_rsp(rs + 1, "timeout_rsp_wait");

    // Ack and test-done already set before the request.
    v = '{4'hD, 4'hF, 24'h004000, 1'b1, -1, -1, 1'b0, 2'd0};
    rs = rsp_cnt;
    fw_status = (32'd1 << 13) | (32'd1 << 16);
    push_exp(v);
    send_req(v.id, v.op, v.body, v.wt);
    n = 0; n2 = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (dbg_state == ST_WAIT_ACK) n++;
      if (dbg_state == ST_WAIT_TEST) n2++;
      if (dbg_state == ST_RESP) got = 1'b1;
    end
    check("preset_wait_ack_cycles", 32'(n), 32'd1);
    check("preset_wait_test_cycles", 32'(n2), 32'd1);
    wait_rsp(rs + 1, "preset_rsp_wait");
    #1 fw_status = 32'd0;

    // Stall in ISSUE, then abort by reset.
    cmd_ready = 1'b0;
    rs = rsp_cnt;
    send_req(4'h7, 4'h1, 24'h000ABC, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_word == 32'h7100_0ABC) n++;
    end
    check("stall_word_held_cycles", 32'(n), 32'd10);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_cmd_valid", 32'(cmd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0; cmd_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_no_rsp", 32'(rsp_cnt), 32'(rs));

    // Recovery after abort.
    run_vec(vecs[0]);

    check("cmd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cms_pix28_cmd_issuer.md
Name: cms_pix28_cmd_issuer

Overview:
- Host-side initiator for the CMS pix28 firmware command word (device_id[31:28], op_code[27:24], body[23:0]).
- Accepts one high-level request at a time and formats the 32-bit command word.
- Delivers the word to the firmware over a valid/ready handshake.
- Tracks completion by polling the firmware status word (ack bits 0-13, test-done bits 14-17, execute-config error bit 31). Optionally auto-issues OP_CODE_W_STATUS_FW_CLEAR.
- Returns one response per request. Sits between the PS-side register bank and the fw_ip1 / fw_ip2 command decoders.

Parameters:
- FW_IP, 1, selects where the execute test-number field sits: 1 → body[17:14], 2 → body[15:12].
- TIMEOUT_CYCLES, 1048576, fw_axi_clk cycles allowed for each wait state; minimum 2; counter is 24 bits wide.
- AUTO_CLEAR, 1, when 1 a status-clear command is issued after every successful or failed wait.

Ports:
- fw_axi_clk  in  1  single clock for the whole block.
- fw_rst  in  1  reset, asynchronous assert, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_device_id  in  4  device_id field.
- req_op_code  in  4  op_code enum value.
- req_body  in  24  body field.
- req_wait_test  in  1  W_EXECUTE only: also wait for the test-done bit.
- cmd_word  out  32  formatted command word.
- cmd_valid  out  1  command word valid.
- cmd_ready  in  1  firmware accepts the word.
- fw_status  in  32  live firmware status word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_code  out  2  response code: 0 OK, 1 ERR_EXEC_CFG, 2 TIMEOUT, 3 BAD_ARG.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values:
  - fw_rst is asynchronous active-high; during it: state=IDLE, cmd_word=0, cmd_valid=0, rsp_valid=0, rsp_code=0, busy=0, req_ready=1 (after reset release), timer=0.
  - fw_rst mid-operation aborts immediately. No response is produced and cmd_valid drops in the same cycle.
- Accept: a request is accepted when req_valid && req_ready. All fields are latched and cmd_word = {id, op, body} is registered.
- BAD_ARG check: applies to W_EXECUTE with req_wait_test=1. If the test-number field is not one-hot, go straight to RESP with rsp_code=3 and no command issued.
- Ack-bit mapping by op code:
  - W_RST_FW→0, W_CFG_STATIC_0→1, R_CFG_STATIC_0→2, W_CFG_STATIC_1→3, R_CFG_STATIC_1→4.
  - W/R_CFG_ARRAY_0→5/6, W/R_CFG_ARRAY_1→7/8, W/R_CFG_ARRAY_2→9/10.
  - R_DATA_ARRAY_0/1→11/12, W_EXECUTE→13.
  - NOOP and W_STATUS_FW_CLEAR have no ack bit.
- Test-done bit = 14 + log2(test_number); one-hot 1,2,4,8 → bits 14,15,16,17.
- States:
  - IDLE: wait for a request.
  - ISSUE: cmd_valid=1 held with a stable cmd_word until cmd_ready. cmd_valid deasserts the cycle after the handshake. Next state is RESP(OK) for NOOP / W_STATUS_FW_CLEAR, otherwise WAIT_ACK. ISSUE has no timeout.
  - WAIT_ACK: timer reloads on entry. fw_status[ack] = 1 → WAIT_TEST if the op is W_EXECUTE && req_wait_test, else CLEAR_ISSUE(OK). Timer reaching TIMEOUT_CYCLES-1 → CLEAR_ISSUE(TIMEOUT).
  - WAIT_TEST (priority order):
    - fw_status[31]=1 → CLEAR_ISSUE(ERR_EXEC_CFG).
    - Else the test-done bit = 1 → CLEAR_ISSUE(OK).
    - Else timeout → CLEAR_ISSUE(TIMEOUT).
    - Timer reloads on entry.
  - CLEAR_ISSUE: if AUTO_CLEAR=0, pass through to RESP in 1 cycle. Otherwise cmd_word = {latched id, 4'hE, 24'h0} with cmd_valid held until cmd_ready, then RESP.
  - RESP: rsp_valid=1 for exactly one cycle with the held rsp_code → IDLE.
- Simultaneous events:
  - Status bit and timeout in the same cycle: the status bit wins.
  - Ack and test-done both already set on entry to WAIT_ACK: one cycle in WAIT_ACK, one in WAIT_TEST.
- Sampling: fw_status is sampled directly. The block does not clear stale bits itself; relying on AUTO_CLEAR is the caller's responsibility.
- Minimum latency: NOOP with cmd_ready tied high gives accept→rsp_valid = 3 cycles (ISSUE, RESP, plus the registration cycle).

Test Plan:
- W_CFG_STATIC_0 request, id=4'h1, body=24'h00_1234, cmd_ready high, fw_status[1] set 5 cycles after the handshake.
  → cmd_word=32'h1200_1234. Then clear word 32'h1E00_0000. rsp_code=0.
- W_EXECUTE, FW_IP=2, body with [15:12]=4'h4, req_wait_test=1; assert status bit 13, then bit 16.
  → rsp_code=0 after bit 16 and not before.
- Same W_EXECUTE, but fw_status[31] asserted together with bit 16.
  → rsp_code=1 (error wins).
- TIMEOUT_CYCLES=16, W_CFG_ARRAY_1 request, status never set.
  → rsp_code=2 exactly 16 cycles after entering WAIT_ACK; clear command still issued.
- W_EXECUTE with test-number field 4'h3 and req_wait_test=1.
  → no cmd_valid; rsp_code=3 on the next RESP.
- cmd_ready held low 10 cycles, then fw_rst pulsed while in ISSUE.
  → cmd_valid=0 immediately, no rsp_valid, req_ready=1 after release.
